// File: rtl/rv_core_pkg.sv
// Shared constants and types for the integer core: data width, register count and address type.
package rv_core_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = $clog2(NREGS);
  localparam int REG_ZERO = 0;

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: set at issue, cleared by writeback, set wins over clear.
// Also exports this cycle's set/clear vectors so the read ports can bypass the registered bits.
module rf_busy_table
  import rv_core_pkg::*;
#(
  parameter int NREGS = rv_core_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issValid,
  input  logic [AW-1:0]    issRd,
  input  logic             clr0,
  input  logic [AW-1:0]    clrAddr0,
  input  logic             clr1,
  input  logic [AW-1:0]    clrAddr1,
  output logic [NREGS-1:0] busyVec,
  output logic [NREGS-1:0] setVec,
  output logic [NREGS-1:0] clrVec
);

  logic [NREGS-1:0] busyReg;
  logic [NREGS-1:0] busyNext;

  // x0 never has a producer, so its bit is tied off and stays at its reset value.
  assign setVec[REG_ZERO] = 1'b0;
  assign clrVec[REG_ZERO] = 1'b0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_bit
    assign setVec[gi] = issValid && (issRd == AW'(gi));
    assign clrVec[gi] = (clr0 && (clrAddr0 == AW'(gi))) || (clr1 && (clrAddr1 == AW'(gi)));
  end

  assign busyNext = setVec | (busyReg & ~clrVec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  assign busyVec = busyReg;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Two-write, NRD-read integer register file with optional write-through bypass and an
// integrated busy scoreboard feeding the hazard logic.
module reg_file_mp_sb
  import rv_core_pkg::*;
#(
  parameter int XLEN          = rv_core_pkg::XLEN,
  parameter int NREGS         = rv_core_pkg::NREGS,
  parameter int NRD           = 2,
  parameter int WRITE_THROUGH = 1,
  localparam int AW           = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regFile [NREGS];
  logic [NREGS-1:0] setVec;
  logic [NREGS-1:0] clrVec;
  logic             wr0Ok;
  logic             wr1Ok;

  assign wr0Ok = we0 && (waddr0 != AW'(REG_ZERO));
  assign wr1Ok = we1 && (waddr1 != AW'(REG_ZERO));

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regFile[r] <= '0;
      end
    end else begin
      if (wr0Ok) regFile[waddr0] <= wdata0;
      if (wr1Ok) regFile[waddr1] <= wdata1;
    end
  end

  rf_busy_table #(
    .NREGS(NREGS)
  ) u_busy (
    .clk     (clk),
    .rst     (rst),
    .issValid(iss_valid),
    .issRd   (iss_rd),
    .clr0    (wr0Ok),
    .clrAddr0(waddr0),
    .clr1    (wr1Ok),
    .clrAddr1(waddr1),
    .busyVec (busy_vec),
    .setVec  (setVec),
    .clrVec  (clrVec)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   portAddr;
    logic [XLEN-1:0] portData;
    logic            portBusy;

    assign portAddr = raddr[gi*AW +: AW];

    always_comb begin
      portData = regFile[portAddr];
      portBusy = busy_vec[portAddr];
      if (WRITE_THROUGH != 0) begin
        if (wr1Ok && (waddr1 == portAddr)) begin
          portData = wdata1;
        end else if (wr0Ok && (waddr0 == portAddr)) begin
          portData = wdata0;
        end
        // A retiring write hides the busy bit unless a new producer issues in the same cycle.
        portBusy = busy_vec[portAddr] & ~(clrVec[portAddr] & ~setVec[portAddr]);
      end
    end

    assign rdata[gi*XLEN +: XLEN] = rst ? '0 : portData;
    assign rbusy[gi]              = rst ? 1'b0 : portBusy;
  end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed checks plus a model-checked random stream for reg_file_mp_sb,
// with a write-through and a non-write-through instance driven in lockstep.
module tb_reg_file_mp_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata, rdataNw;
  logic [NRD-1:0]    rbusy, rbusyNw;
  logic              we0, we1, iss_valid;
  logic [AW-1:0]     waddr0, waddr1, iss_rd;
  logic [XLEN-1:0]   wdata0, wdata1;
  logic [NREGS-1:0]  busyVec, busyVecNw;

  int errCnt = 0;
  int chkCnt = 0;

  logic [XLEN-1:0]  mdl [NREGS];
  logic [NREGS-1:0] mBusy;

  always #5 clk = ~clk;

  reg_file_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .WRITE_THROUGH(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busyVec)
  );

  reg_file_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .WRITE_THROUGH(0)) dutNw (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdataNw), .rbusy(rbusyNw),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busyVecNw)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_rd = '0;
  endtask

  task automatic setRd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rdOf(input logic [NRD*XLEN-1:0] v, input int p);
    return v[p*XLEN +: XLEN];
  endfunction

  initial begin
    rst = 1'b1;
    raddr = '0;
    idle();
    #1;
    checkVal("reset_busy_vec", 64'(busyVec), 64'h0);
    checkVal("reset_rdata0", 64'(rdOf(rdata, 0)), 64'h0);
    step(); step();
    rst = 1'b0;

    // Reset: preload r5, mark it busy, then reset mid-cycle
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    step(); idle();
    iss_valid = 1'b1; iss_rd = 5'd5;
    step(); idle();
    setRd(0, 5'd5);
    #1;
    checkVal("preload_r5", 64'(rdOf(rdata, 0)), 64'hDEADBEEF);
    checkVal("preload_busy5", 64'(busyVec[5]), 64'h1);
    #2 rst = 1'b1;
    #1;
    checkVal("midrst_rdata0", 64'(rdOf(rdata, 0)), 64'h0);
    checkVal("midrst_busy_vec", 64'(busyVec), 64'h0);
    checkVal("midrst_rbusy", 64'(rbusy), 64'h0);
    step();
    rst = 1'b0;
    step();
    checkVal("post_rst_r5", 64'(rdOf(rdata, 0)), 64'h0);
    checkVal("post_rst_nw_r5", 64'(rdOf(rdataNw, 0)), 64'h0);

    // x0 is never written nor busy
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234; setRd(0, 5'd0);
    #1;
    checkVal("x0_bypass", 64'(rdOf(rdata, 0)), 64'h0);
    step(); idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    step(); idle();
    #1;
    checkVal("x0_read", 64'(rdOf(rdata, 0)), 64'h0);
    checkVal("x0_busy", 64'(busyVec[0]), 64'h0);
    checkVal("x0_rbusy", 64'(rbusy[0]), 64'h0);

    // Dual-write collision: port 1 wins
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    setRd(0, 5'd7);
    #1;
    checkVal("collide_bypass", 64'(rdOf(rdata, 0)), 64'h22);
    checkVal("collide_nw_old", 64'(rdOf(rdataNw, 0)), 64'h0);
    step(); idle();
    checkVal("collide_r7", 64'(rdOf(rdata, 0)), 64'h22);
    checkVal("collide_nw_r7", 64'(rdOf(rdataNw, 0)), 64'h22);

    // Write-through bypass on read port 1
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5; setRd(1, 5'd3);
    #1;
    checkVal("wt_bypass", 64'(rdOf(rdata, 1)), 64'hA5A5A5A5);
    checkVal("nwt_old", 64'(rdOf(rdataNw, 1)), 64'h0);
    step(); idle();
    checkVal("nwt_new", 64'(rdOf(rdataNw, 1)), 64'hA5A5A5A5);

    // Scoreboard on r9
    iss_valid = 1'b1; iss_rd = 5'd9;
    step(); idle();
    setRd(0, 5'd9); setRd(1, 5'd9);
    #1;
    checkVal("sb_busy9", 64'(busyVec[9]), 64'h1);
    checkVal("sb_rbusy", 64'(rbusy), 64'h3);
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    #1;
    checkVal("sb_clear_bypass", 64'(rbusy[0]), 64'h0);
    checkVal("sb_nw_no_bypass", 64'(rbusyNw[0]), 64'h1);
    step(); idle();
    checkVal("sb_cleared", 64'(busyVec[9]), 64'h0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    #1;
    checkVal("sb_set_wins_rbusy", 64'(rbusy[1]), 64'h1);
    step(); idle();
    checkVal("sb_set_wins_bit", 64'(busyVec[9]), 64'h1);
    checkVal("sb_r9_data", 64'(rdOf(rdata, 1)), 64'h77);

    // Random stream against a reference model, starting from reset
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    mBusy = '0;
    for (int c = 0; c < 300; c++) begin
      logic [XLEN-1:0]  expD;
      logic             expB;
      logic [AW-1:0]    a;
      logic [NREGS-1:0] nb;
      we0 = 1'($urandom_range(0, 1)); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom_range(0, 7));
      setRd(0, 5'($urandom_range(0, 7)));
      setRd(1, 5'($urandom_range(0, 7)));
      #2;
      checkVal("rnd_busy_vec", 64'(busyVec), 64'(mBusy));
      for (int p = 0; p < NRD; p++) begin
        a = raddr[p*AW +: AW];
        expD = mdl[a];
        if (a != 0 && we1 && waddr1 == a) expD = wdata1;
        else if (a != 0 && we0 && waddr0 == a) expD = wdata0;
        checkVal("rnd_rdata", 64'(rdOf(rdata, p)), 64'(expD));
        checkVal("rnd_rdata_nw", 64'(rdOf(rdataNw, p)), 64'(mdl[a]));
        expB = mBusy[a];
        if (a != 0 && ((we0 && waddr0 == a) || (we1 && waddr1 == a)) && !(iss_valid && iss_rd == a))
          expB = 1'b0;
        checkVal("rnd_rbusy", 64'(rbusy[p]), 64'(expB));
        checkVal("rnd_rbusy_nw", 64'(rbusyNw[p]), 64'(mBusy[a]));
      end
      nb = mBusy;
      for (int r = 1; r < NREGS; r++) begin
        if ((we0 && waddr0 == 5'(r)) || (we1 && waddr1 == 5'(r))) nb[r] = 1'b0;
        if (iss_valid && iss_rd == 5'(r)) nb[r] = 1'b1;
      end
      if (we0 && waddr0 != 0) mdl[waddr0] = wdata0;
      if (we1 && waddr1 != 0) mdl[waddr1] = wdata1;
      mBusy = nb;
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
